fcmp_flag_wb: RTL

- Downstream stage of the FP compare unit: accepts each compare result (6-bit flags, 68-bit packed vector result) with its tag, buffers it in a small FIFO, and evaluates the associated jump condition.
- Presents the results in order to the flag/writeback port using a valid/ready handshake.
- Decouples compare timing from writeback-port arbitration. The compare stage never stalls while there is space.

---
 rtl/fcmp_wb_pkg.sv | 41 ++++
 rtl/fcmp_wb_cond.sv | 39 +++
 rtl/fcmp_flag_wb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fcmp_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcmp_wb_pkg
// Description : Shared definitions for the FP compare flag/writeback stage:
//               jump condition codes, flag bit positions and the FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fcmp_wb_pkg;

  // Jump condition codes (jumpType[3:1])
  localparam logic [2:0] FCMPWB_Z   = 3'd0;
  localparam logic [2:0] FCMPWB_C   = 3'd1;
  localparam logic [2:0] FCMPWB_S   = 3'd2;
  localparam logic [2:0] FCMPWB_UN  = 3'd3;
  localparam logic [2:0] FCMPWB_CZ  = 3'd4;
  localparam logic [2:0] FCMPWB_SZ  = 3'd5;
  localparam logic [2:0] FCMPWB_AL  = 3'd6;
  localparam logic [2:0] FCMPWB_ZNU = 3'd7;

  // Flag vector bit positions: {~C, unord, 0, S, Z, unord}
  localparam int FLG_NC  = 5;
  localparam int FLG_UN  = 4;
  localparam int FLG_S   = 2;
  localparam int FLG_Z   = 1;
  localparam int FLG_UN0 = 0;

  // Widest tag an entry can hold; narrower tags are zero-extended.
  localparam int FCMPWB_TAG_MAX = 16;
  localparam int FCMPWB_RES_W   = 68;

  typedef struct packed {
    logic [FCMPWB_TAG_MAX-1:0] tag;
    logic [5:0]                flags;
    logic [FCMPWB_RES_W-1:0]   res_pkd;
    logic                      jmp_vld;
    logic                      jmp_taken;
    logic                      vec;
  } fcmp_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fcmp_wb_cond.sv
`default_nettype none
// ============================================================================
// Module      : fcmp_wb_cond
// Description : Combinational jump-condition evaluator for a compare result.
//               Vector results and jumpType[4]=1 carry no jump evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module fcmp_wb_cond
  import fcmp_wb_pkg::*;
(
  input  logic [5:0] i_flags,
  input  logic [4:0] i_jumpType,
  input  logic       i_vec,
  output logic       o_jmp_vld,
  output logic       o_taken
);

  logic w_cond;

  // Select the raw condition from the flags, then apply inversion and gating
  always_comb begin
    w_cond = 1'b0;
    case (i_jumpType[3:1])
      FCMPWB_Z:   w_cond = i_flags[FLG_Z];
      FCMPWB_C:   w_cond = ~i_flags[FLG_NC];
      FCMPWB_S:   w_cond = i_flags[FLG_S];
      FCMPWB_UN:  w_cond = i_flags[FLG_UN0];
      FCMPWB_CZ:  w_cond = ~i_flags[FLG_NC] | i_flags[FLG_Z];
      FCMPWB_SZ:  w_cond = i_flags[FLG_S] | i_flags[FLG_Z];
      FCMPWB_AL:  w_cond = 1'b1;
      FCMPWB_ZNU: w_cond = i_flags[FLG_Z] & ~i_flags[FLG_UN0];
      default:    w_cond = 1'b0;
    endcase
    o_jmp_vld = ~i_vec & ~i_jumpType[4];
    o_taken   = (w_cond ^ i_jumpType[0]) & o_jmp_vld;
  end

endmodule
`default_nettype wire

// File: rtl/fcmp_flag_wb.sv
`default_nettype none
// ============================================================================
// Module      : fcmp_flag_wb
// Description : Buffers FP compare results in a small in-order FIFO, evaluates
//               the jump condition at push time and presents entries to the
//               flag/writeback port over valid/ready. in_rdy and out_vld come
//               from the registered count only (no bypass, no ready-through).
//               Optional: `define FCMP_WB_STICKY_EN for a sticky unordered flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fcmp_flag_wb
  import fcmp_wb_pkg::*;
#(
  parameter int TAG_W = 9,   // must not exceed FCMPWB_TAG_MAX
  parameter int DEPTH = 4    // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [5:0]       in_flags,
  input  logic [67:0]      in_res_pkd,
  input  logic             in_vec,
  input  logic [4:0]       in_jumpType,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [TAG_W-1:0] out_tag,
  output logic [5:0]       out_flags,
  output logic [67:0]      out_res_pkd,
  output logic             out_jmp_vld,
  output logic             out_jmp_taken,
  output logic             sticky_unord,
  input  logic             clr_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fcmp_wb_entry_t   r_mem [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_jmp_vld;
  logic             w_taken;
  fcmp_wb_entry_t   w_wr_entry;
  fcmp_wb_entry_t   w_head;

  assign in_rdy  = (r_count != CNT_W'(DEPTH));
  assign out_vld = (r_count != '0);
  assign w_push  = in_vld & in_rdy & ~flush;
  assign w_pop   = out_vld & out_rdy & ~flush;

  fcmp_wb_cond u_cond (
    .i_flags    (in_flags),
    .i_jumpType (in_jumpType),
    .i_vec      (in_vec),
    .o_jmp_vld  (w_jmp_vld),
    .o_taken    (w_taken)
  );

  // Assemble the entry written on push; vec is only kept when sticky needs it
  always_comb begin
    w_wr_entry           = '0;
    w_wr_entry.tag       = FCMPWB_TAG_MAX'(in_tag);
    w_wr_entry.flags     = in_flags;
    w_wr_entry.res_pkd   = in_res_pkd;
    w_wr_entry.jmp_vld   = w_jmp_vld;
    w_wr_entry.jmp_taken = w_taken;
`ifdef FCMP_WB_STICKY_EN
    w_wr_entry.vec       = in_vec;
`else
    w_wr_entry.vec       = 1'b0;
`endif
  end

  // Pointer and occupancy control; reset dominates flush, flush dominates traffic
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are don't-care while not counted as valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Head presentation, forced to zero when nothing is valid
  always_comb begin
    out_tag       = '0;
    out_flags     = '0;
    out_res_pkd   = '0;
    out_jmp_vld   = 1'b0;
    out_jmp_taken = 1'b0;
    if (out_vld) begin
      out_tag       = w_head.tag[TAG_W-1:0];
      out_flags     = w_head.flags;
      out_res_pkd   = w_head.res_pkd;
      out_jmp_vld   = w_head.jmp_vld;
      out_jmp_taken = w_head.jmp_taken;
    end
  end

`ifdef FCMP_WB_STICKY_EN
  logic r_sticky;

  // Sticky unordered: set on popping a scalar unordered result, set beats clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sticky <= 1'b0;
    end else if (w_pop && w_head.flags[FLG_UN0] && !w_head.vec) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign sticky_unord = r_sticky;
`else
  assign sticky_unord = 1'b0;
`endif

  // Bits intentionally not consumed (upper tag bits, vec/clr in default build)
  logic w_unused_bits;
  assign w_unused_bits = ^{w_head.tag, w_head.vec, clr_sticky};

endmodule
`default_nettype wire
